// File: rtl/apb_counter_timer.sv
// APB down-counting timer with one-shot/periodic modes and a masked level interrupt.
// Optional prescaler built when TIMER_PRESCALE_EN is defined.
module apb_counter_timer #(
    parameter int PRESCALE_W = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        irq
);

    localparam logic [2:0] A_LOAD     = 3'd0;
    localparam logic [2:0] A_VALUE    = 3'd1;
    localparam logic [2:0] A_CTRL     = 3'd2;
    localparam logic [2:0] A_INTCLR   = 3'd3;
    localparam logic [2:0] A_RIS      = 3'd4;
    localparam logic [2:0] A_MIS      = 3'd5;
    localparam logic [2:0] A_PRESCALE = 3'd6;

    logic [31:0] load_reg;
    logic [31:0] value_reg;
    logic        ctrl_en;
    logic        ctrl_periodic;
    logic        ctrl_ie;
    logic        ris;

    logic [2:0]  reg_sel;
    logic        wr_en;
    logic        rd_setup;
    logic        wr_load;
    logic        wr_ctrl;
    logic        wr_intclr;
    logic        tick;
    logic        zero_hit;
    logic [31:0] prescale_rd;
    logic [31:0] rd_mux;

    assign reg_sel   = paddr[4:2];
    assign wr_en     = psel & penable & pwrite;
    assign rd_setup  = psel & ~penable & ~pwrite;
    assign wr_load   = wr_en && (reg_sel == A_LOAD);
    assign wr_ctrl   = wr_en && (reg_sel == A_CTRL);
    assign wr_intclr = wr_en && (reg_sel == A_INTCLR);

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_reg;
    logic [PRESCALE_W-1:0] presc_cnt;
    logic                  wr_prescale;
    logic                  unused_ok;

    assign wr_prescale = wr_en && (reg_sel == A_PRESCALE);

    // Terminal count at zero, so the first tick lands on the first enabled cycle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            prescale_reg <= '0;
            presc_cnt    <= '0;
        end else begin
            if (wr_prescale)
                prescale_reg <= pwdata[PRESCALE_W-1:0];
            if (!ctrl_en || wr_prescale)
                presc_cnt <= '0;
            else if (presc_cnt == '0)
                presc_cnt <= prescale_reg;
            else
                presc_cnt <= presc_cnt - 1'b1;
        end
    end

    assign tick        = ctrl_en && (presc_cnt == '0);
    assign prescale_rd = 32'(prescale_reg);
    assign unused_ok   = ^{paddr[31:5], paddr[1:0]};
`else
    logic unused_ok;

    assign tick        = ctrl_en;
    assign prescale_rd = '0;
    assign unused_ok   = ^{paddr[31:5], paddr[1:0], PRESCALE_W[0]};
`endif

    // A LOAD write in the same cycle pre-empts the tick entirely.
    assign zero_hit = tick && (value_reg == '0) && !wr_load;

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            A_LOAD:     rd_mux = load_reg;
            A_VALUE:    rd_mux = value_reg;
            A_CTRL:     rd_mux = {29'd0, ctrl_ie, ctrl_periodic, ctrl_en};
            A_RIS:      rd_mux = {31'd0, ris};
            A_MIS:      rd_mux = {31'd0, ris & ctrl_ie};
            A_PRESCALE: rd_mux = prescale_rd;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            load_reg      <= '0;
            value_reg     <= '0;
            ctrl_en       <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_ie       <= 1'b0;
            ris           <= 1'b0;
            prdata        <= '0;
        end else begin
            if (wr_load)
                load_reg <= pwdata;
            if (wr_ctrl)
                {ctrl_ie, ctrl_periodic, ctrl_en} <= pwdata[2:0];

            if (wr_load)
                value_reg <= pwdata;
            else if (tick) begin
                if (value_reg != '0)
                    value_reg <= value_reg - 32'd1;
                else if (ctrl_periodic)
                    value_reg <= load_reg;
            end

            // Zero-reach beats INTCLR; a same-cycle CTRL write keeps its EN value.
            if (zero_hit) begin
                ris <= 1'b1;
                if (!ctrl_periodic && !wr_ctrl)
                    ctrl_en <= 1'b0;
            end else if (wr_intclr) begin
                ris <= 1'b0;
            end

            prdata <= rd_setup ? rd_mux : '0;
        end
    end

    assign irq = ris & ctrl_ie;

endmodule

// File: tb/tb_apb_counter_timer.sv
// Directed self-checking bench for apb_counter_timer; prescale scenario runs when
// TIMER_PRESCALE_EN is defined for both bench and design.
module tb_apb_counter_timer;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    apb_counter_timer dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .irq     (irq)
    );

    always #5 HCLK = ~HCLK;

    // All bus tasks are entered and left at a falling edge.
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge HCLK);
        penable = 1'b1;
        @(negedge HCLK);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge HCLK);
        penable = 1'b1;
        d = prdata;
        @(negedge HCLK);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        n_total++;
        if (prdata !== 32'd0) $display("FAIL reset_prdata: got %h want 0", prdata); else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            apb_read(32'(i * 4), rd);
            n_total++;
            if (rd !== 32'd0) $display("FAIL reset_reg_%0h: got %h want 0", i * 4, rd); else n_pass++;
        end
    endtask

    task automatic test_readback();
        logic [31:0] rd;
        apb_write(32'h00, 32'hDEADBEEF);
        apb_read(32'h00, rd);
        n_total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL rb_load: got %h want deadbeef", rd); else n_pass++;
        n_total++;
        if (prdata !== 32'd0) $display("FAIL rb_prdata_idle: got %h want 0", prdata); else n_pass++;
        apb_write(32'h04, 32'h00001234);
        apb_read(32'h04, rd);
        n_total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL rb_value_ro: got %h want deadbeef", rd); else n_pass++;
        apb_write(32'h1C, 32'hFFFFFFFF);
        apb_read(32'h1C, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL rb_unused: got %h want 0", rd); else n_pass++;
        apb_read(32'h0C, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL rb_intclr: got %h want 0", rd); else n_pass++;
        apb_write(32'h08, 32'hFFFFFFF8);
        apb_read(32'h08, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL rb_ctrl_upper: got %h want 0", rd); else n_pass++;
`ifndef TIMER_PRESCALE_EN
        apb_write(32'h18, 32'h0000000F);
        apb_read(32'h18, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL rb_prescale_absent: got %h want 0", rd); else n_pass++;
`endif
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        logic [31:0] exp_v [4] = '{32'd3, 32'd2, 32'd1, 32'd0};
        for (int n = 0; n < 4; n++) begin
            apb_write(32'h08, 32'h0);
            apb_write(32'h00, 32'd3);
            apb_write(32'h0C, 32'h0);
            apb_write(32'h08, 32'h5);
            idle(n);
            apb_read(32'h04, rd);
            n_total++;
            if (rd !== exp_v[n]) $display("FAIL os_value_%0d: got %0d want %0d", n, rd, exp_v[n]); else n_pass++;
        end
        apb_read(32'h10, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL os_ris: got %h want 1", rd); else n_pass++;
        apb_read(32'h14, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL os_mis: got %h want 1", rd); else n_pass++;
        n_total++;
        if (irq !== 1'b1) $display("FAIL os_irq: got %b want 1", irq); else n_pass++;
        apb_read(32'h08, rd);
        n_total++;
        if (rd !== 32'h4) $display("FAIL os_ctrl_en_cleared: got %h want 4", rd); else n_pass++;
        apb_read(32'h04, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL os_no_wrap: got %h want 0", rd); else n_pass++;
    endtask

    task automatic test_periodic();
        logic [31:0] rd;
        logic [31:0] exp_v [6] = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0};
        logic [31:0] exp_r [3] = '{32'd0, 32'd0, 32'd1};
        apb_write(32'h08, 32'h0);
        apb_write(32'h00, 32'd2);
        apb_write(32'h0C, 32'h0);
        apb_write(32'h08, 32'h3);
        for (int k = 0; k < 3; k++) begin
            apb_read(32'h10, rd);
            n_total++;
            if (rd !== exp_r[k]) $display("FAIL per_ris_%0d: got %h want %h", k, rd, exp_r[k]); else n_pass++;
        end
        for (int n = 0; n < 6; n++) begin
            apb_write(32'h08, 32'h0);
            apb_write(32'h00, 32'd2);
            apb_write(32'h0C, 32'h0);
            apb_write(32'h08, 32'h3);
            idle(n);
            apb_read(32'h04, rd);
            n_total++;
            if (rd !== exp_v[n]) $display("FAIL per_value_%0d: got %0d want %0d", n, rd, exp_v[n]); else n_pass++;
        end
        apb_read(32'h10, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL per_ris_final: got %h want 1", rd); else n_pass++;
        apb_read(32'h14, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL per_mis: got %h want 0", rd); else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL per_irq: got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_load_priority();
        logic [31:0] rd;
        apb_write(32'h00, 32'd100);
        apb_read(32'h04, rd);
        n_total++;
        if (rd !== 32'd100) $display("FAIL lp_value: got %0d want 100", rd); else n_pass++;
        apb_write(32'h00, 32'd0);
        apb_write(32'h0C, 32'h0);
        apb_read(32'h10, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL lp_load0_ris: got %h want 1", rd); else n_pass++;
        apb_read(32'h04, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL lp_load0_value: got %h want 0", rd); else n_pass++;
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        apb_write(32'h08, 32'h0);
        apb_write(32'h00, 32'd2);
        apb_write(32'h0C, 32'h0);
        apb_write(32'h08, 32'h1);
        idle(1);
        apb_write(32'h0C, 32'h0);
        apb_read(32'h10, rd);
        n_total++;
        if (rd !== 32'd1) $display("FAIL col_ris_kept: got %h want 1", rd); else n_pass++;
        apb_write(32'h0C, 32'h0);
        apb_read(32'h10, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL col_ris_cleared: got %h want 0", rd); else n_pass++;
        apb_read(32'h08, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL col_ctrl: got %h want 0", rd); else n_pass++;
    endtask

    task automatic test_midcount_reset();
        logic [31:0] rd;
        logic [31:0] offs [5] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14};
        apb_write(32'h08, 32'h0);
        apb_write(32'h00, 32'd0);
        apb_write(32'h08, 32'h7);
        apb_write(32'h00, 32'd7);
        idle(1);
        // LOAD write whose enable phase coincides with the reset edge must not commit.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h55;
        @(negedge HCLK);
        penable = 1'b1;
        HRESET  = 1'b1;
        n_total++;
        if (irq !== 1'b1) $display("FAIL mr_irq_before: got %b want 1", irq); else n_pass++;
        @(negedge HCLK);
        HRESET = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        n_total++;
        if (irq !== 1'b0) $display("FAIL mr_irq_after: got %b want 0", irq); else n_pass++;
        n_total++;
        if (prdata !== 32'd0) $display("FAIL mr_prdata: got %h want 0", prdata); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            apb_read(offs[i], rd);
            n_total++;
            if (rd !== 32'd0) $display("FAIL mr_reg_%0h: got %h want 0", offs[i], rd); else n_pass++;
        end
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] rd;
        int          waits [4] = '{0, 1, 4, 5};
        logic [31:0] exp_v [4] = '{32'd2, 32'd1, 32'd1, 32'd0};
        for (int k = 0; k < 4; k++) begin
            apb_write(32'h08, 32'h0);
            apb_write(32'h18, 32'd3);
            apb_write(32'h00, 32'd2);
            apb_write(32'h08, 32'h1);
            idle(waits[k]);
            apb_read(32'h04, rd);
            n_total++;
            if (rd !== exp_v[k]) $display("FAIL ps_value_%0d: got %0d want %0d", waits[k], rd, exp_v[k]); else n_pass++;
        end
        apb_read(32'h18, rd);
        n_total++;
        if (rd !== 32'd3) $display("FAIL ps_readback: got %h want 3", rd); else n_pass++;
        apb_write(32'h08, 32'h0);
    endtask
`endif

    initial begin
        HRESET = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        test_reset();
        test_readback();
        test_oneshot();
        test_periodic();
        test_load_priority();
        test_collision();
        test_midcount_reset();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
